// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The optional tag byte is enabled by defining UART_ARB_TAG_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StTag,
        StData
    } arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'hA0;

    localparam int unsigned DEFAULT_NUM_REQ = 4;
    localparam int unsigned DEFAULT_MAX_PKT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// last_grant+1 with wrap-around.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       found
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned SW = GW + 1;

    logic [2*NUM_REQ-1:0] req2;
    logic [NUM_REQ-1:0]   rot;
    logic [SW-1:0]        pick;
    logic [SW-1:0]        sum;

    assign req2 = {req, req};

    always_comb begin
        // rot[k] is the request of index (last_grant + 1 + k) mod NUM_REQ
        rot   = NUM_REQ'(req2 >> (32'(last_grant) + 32'd1));
        found = 1'b0;
        pick  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pick  = SW'(k);
            end
        end
        sum = {1'b0, last_grant} + SW'(1) + pick;
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        grant = sum[GW-1:0];
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter in front of a UART transmitter.
// Define UART_ARB_TAG_EN to prefix each granted packet with an owner tag byte.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned MAX_PKT = DEFAULT_MAX_PKT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_PKT + 1);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] arb_grant;
    logic          arb_found;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_valid, sel_last, xfer, pkt_end;
    logic [7:0]    sel_data;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .found      (arb_found)
    );

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign sel_data  = req_data[{grant_q, 3'b000} +: 8];
    assign xfer      = (state_q == StData) && sel_valid && tx_ready;
    assign pkt_end   = xfer && (sel_last || (cnt_q == CW'(MAX_PKT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) state_d = StArb;
            end
            StArb: begin
                cnt_d = '0;
                if (arb_found) begin
                    grant_d = arb_grant;
                    busy_d  = 1'b1;
`ifdef UART_ARB_TAG_EN
                    state_d = StTag;
`else
                    state_d = StData;
`endif
                end else begin
                    // requester withdrew before arbitration
                    state_d = StIdle;
                end
            end
`ifdef UART_ARB_TAG_EN
            StTag: begin
                if (tx_ready) state_d = StData;
            end
`endif
            StData: begin
                // no timeout: an owner that stalls keeps the grant
                if (xfer) cnt_d = cnt_q + CW'(1);
                if (pkt_end) begin
                    last_grant_d = grant_q;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        unique case (state_q)
`ifdef UART_ARB_TAG_EN
            StTag: begin
                tx_valid = 1'b1;
                tx_data  = TAG_BASE | 8'(grant_q);
            end
`endif
            StData: begin
                tx_valid           = sel_valid;
                tx_data            = sel_data;
                req_ready[grant_q] = tx_ready;
            end
            default: ;
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: cycle table, directed packet sequences
// and randomized traffic against a packet-level reference model.
module tb_uart_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int MAX_PKT = 16;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [1:0]           grant_id;
    logic                 busy;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NUM_REQ(NUM_REQ),
        .MAX_PKT(MAX_PKT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] b;
        int         id;
        bit         tag;
        bit         first;
    } exp_t;

    typedef struct {
        logic [3:0]  v;
        logic        tr;
        logic [15:0] exp;
    } vec_t;

    logic [7:0] qd[NUM_REQ][$];
    bit         ql[NUM_REQ][$];
    exp_t       exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] out_vec();
        return {tx_valid, tx_data, req_ready, busy, (busy ? grant_id : 2'b00)};
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < NUM_REQ; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
    endtask

    task automatic add_byte(input int id, input logic [7:0] b, input bit last);
        qd[id].push_back(b);
        ql[id].push_back(last);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        clear_queues();
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", {16'h0, out_vec()}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Packet-level model: round-robin over requesters with pending bytes,
    // each grant runs to req_last or MAX_PKT bytes.
    task automatic build_model();
        logic [7:0] md[NUM_REQ][$];
        bit         ml[NUM_REQ][$];
        int         lg = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            md[i] = qd[i];
            ml[i] = ql[i];
        end
        exp_q.delete();
        forever begin
            int  win = -1;
            int  n = 0;
            bit  done = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c = (lg + k) % NUM_REQ;
                if (win < 0 && md[c].size() > 0) win = c;
            end
            if (win < 0) break;
            if (TAG_EN) exp_q.push_back('{b: 8'(8'hA0 | win), id: win, tag: 1'b1, first: 1'b1});
            while (md[win].size() > 0 && !done) begin
                logic [7:0] b = md[win].pop_front();
                bit         l = ml[win].pop_front();
                n++;
                exp_q.push_back('{b: b, id: win, tag: 1'b0, first: (n == 1) && !TAG_EN});
                if (l || n == MAX_PKT) done = 1'b1;
            end
            if (!done) break;
            lg = win;
        end
    endtask

    task automatic run_stream(input string name, input int stop_after, input int ready_pct,
                              input int drop_pct, input int stall_after);
        int         n;
        int         got = 0;
        int         stall_left = 0;
        bit         stall_bad = 1'b0;
        logic [7:0] stall_ref = 8'h00;
        build_model();
        n = exp_q.size();
        if (stop_after > 0 && stop_after < n) n = stop_after;
        for (int cyc = 0; cyc < 4000 && got < n; cyc++) begin
            logic [NUM_REQ-1:0]   rv = '0;
            logic [NUM_REQ-1:0]   rl = '0;
            logic [NUM_REQ*8-1:0] rd = '0;
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (qd[i].size() > 0) begin
                    rv[i]        = 1'b1;
                    rd[8*i +: 8] = qd[i][0];
                    rl[i]        = ql[i][0];
                end
            end
            if (!exp_q[got].first && $urandom_range(99) < drop_pct) rv[exp_q[got].id] = 1'b0;
            req_valid = rv;
            req_data  = rd;
            req_last  = rl;
            tx_ready  = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
            #1;
            if (stall_left > 0) begin
                if (stall_left == 50) stall_ref = tx_data;
                else if (tx_data !== stall_ref) stall_bad = 1'b1;
                if (req_ready !== '0 || tx_valid !== 1'b1) stall_bad = 1'b1;
                stall_left--;
                if (stall_left == 0) check({name, "_stall"}, {31'h0, stall_bad}, 32'h0);
            end else if (tx_valid && tx_ready) begin
                exp_t       e = exp_q[got];
                logic [3:0] err = e.tag ? 4'b0000 : 4'(1 << e.id);
                check({name, "_xfer"}, {18'h0, tx_data, grant_id, req_ready},
                      {18'h0, e.b, 2'(e.id), err});
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i] && rv[i]) begin
                        void'(qd[i].pop_front());
                        void'(ql[i].pop_front());
                    end
                end
                got++;
                if (got == stall_after) stall_left = 50;
            end
        end
        check({name, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        vec_t tbl[$];

        do_reset();

        // Cycle table: requesters 0 and 2 each send one byte with req_last.
        tbl.push_back('{v: 4'b0101, tr: 1'b1, exp: {1'b0, 8'h00, 4'b0000, 1'b0, 2'd0}});
        tbl.push_back('{v: 4'b0101, tr: 1'b1, exp: {1'b0, 8'h00, 4'b0000, 1'b0, 2'd0}});
        if (TAG_EN)
            tbl.push_back('{v: 4'b0101, tr: 1'b1, exp: {1'b1, 8'hA0, 4'b0000, 1'b1, 2'd0}});
        tbl.push_back('{v: 4'b0101, tr: 1'b1, exp: {1'b1, 8'h10, 4'b0001, 1'b1, 2'd0}});
        tbl.push_back('{v: 4'b0100, tr: 1'b1, exp: {1'b0, 8'h00, 4'b0000, 1'b0, 2'd0}});
        tbl.push_back('{v: 4'b0100, tr: 1'b1, exp: {1'b0, 8'h00, 4'b0000, 1'b0, 2'd0}});
        if (TAG_EN)
            tbl.push_back('{v: 4'b0100, tr: 1'b1, exp: {1'b1, 8'hA2, 4'b0000, 1'b1, 2'd2}});
        tbl.push_back('{v: 4'b0100, tr: 1'b1, exp: {1'b1, 8'h32, 4'b0100, 1'b1, 2'd2}});
        tbl.push_back('{v: 4'b0000, tr: 1'b1, exp: {1'b0, 8'h00, 4'b0000, 1'b0, 2'd0}});
        foreach (tbl[r]) begin
            @(negedge clk);
            req_valid = tbl[r].v;
            req_last  = 4'b1111;
            req_data  = 32'h4332_2110;
            tx_ready  = tbl[r].tr;
            #1 check("table_row", {16'h0, out_vec()}, {16'h0, tbl[r].exp});
        end

        // Requester 1 packet stays contiguous while requester 3 waits.
        do_reset();
        add_byte(1, 8'h11, 1'b0);
        add_byte(1, 8'h22, 1'b0);
        add_byte(1, 8'h33, 1'b1);
        add_byte(3, 8'h44, 1'b1);
        add_byte(3, 8'h55, 1'b1);
        run_stream("contig", 0, 60, 30, 0);

        // 20 bytes without req_last: forced release after MAX_PKT.
        do_reset();
        for (int i = 0; i < 20; i++) add_byte(0, 8'(i), 1'b0);
        add_byte(1, 8'hB1, 1'b1);
        run_stream("maxpkt", 0, 100, 0, 0);
        repeat (10) @(negedge clk);
        #1 check("hold_grant", {30'h0, busy, 1'b0}, {30'h0, 1'b1, 1'b0});
        check("hold_owner", {30'h0, grant_id}, 32'h0);

        // Long transmitter stall mid-packet.
        do_reset();
        add_byte(2, 8'h5A, 1'b0);
        add_byte(2, 8'hA5, 1'b0);
        add_byte(2, 8'hC3, 1'b1);
        run_stream("stall", 0, 100, 0, 2);

        // Single byte from requester 2 (preceded by A2 when tagging).
        do_reset();
        add_byte(2, 8'h3C, 1'b1);
        run_stream("tag_byte", 0, 100, 0, 0);

        // Asynchronous reset in the middle of a packet.
        do_reset();
        add_byte(0, 8'h01, 1'b1);
        for (int i = 0; i < 5; i++) add_byte(1, 8'(8'h60 + i), i == 4);
        run_stream("pre_rst", 3, 100, 0, 0);
        @(negedge clk);
        #1 check("busy_before_rst", {30'h0, busy, tx_valid}, 32'h3);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {16'h0, out_vec()}, 32'h0);
        req_valid = '0;
        clear_queues();
        @(negedge clk);
        rst_n = 1'b1;
        add_byte(0, 8'hAA, 1'b1);
        add_byte(1, 8'hBB, 1'b1);
        run_stream("post_rst", 0, 100, 0, 0);

        // Randomized traffic with tx_ready back-pressure and owner valid drops.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int i = 0; i < NUM_REQ; i++) begin
                int npk = $urandom_range(2, 0);
                for (int p = 0; p < npk; p++) begin
                    int len = $urandom_range(20, 1);
                    for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
                end
            end
            run_stream("rand", 0, 70, 20, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter MAX_PKT, default 16: maximum bytes per packet before a forced grant release.
REQ-003 clk  in  1: single clock; all logic on posedge.
REQ-004 rst_n  in  1: asynchronous, active-low reset.
REQ-005 req_valid  in  NUM_REQ: per-requester byte valid.
REQ-006 req_data  in  NUM_REQ*8: per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  in  NUM_REQ: marks the final byte of a packet.
REQ-008 req_ready  out  NUM_REQ: per-requester accept; one-hot or zero.
REQ-009 tx_data  out  8: byte to the UART transmitter.
REQ-010 tx_valid  out  1: byte offered to the transmitter.
REQ-011 tx_ready  in  1: transmitter ready (data_in_ready of the TX).
REQ-012 grant_id  out  $clog2(NUM_REQ): index of the current owner; valid while busy=1.
REQ-013 busy  out  1: a packet is in progress.

Function
REQ-014 The transmitter and the arbiter SHALL transfer a byte only on a cycle where tx_valid=1 and tx_ready=1.
REQ-015 FSM states SHALL be IDLE, ARB, TAG, DATA.
REQ-016 IDLE SHALL move to ARB on the cycle after any req_valid bit is high.
REQ-017 ARB SHALL pick, in one cycle, the first requester with req_valid=1 searching upward from (last_grant+1) mod NUM_REQ with wrap-around, then latch grant_id and raise busy.
REQ-018 ARB SHALL go to TAG when the tag feature is compiled in, otherwise to DATA.
REQ-019 In DATA, tx_valid SHALL equal req_valid[grant_id], tx_data SHALL equal req_data of grant_id, and req_ready[grant_id] SHALL equal tx_ready.
REQ-020 A DATA transfer with req_last=1, or the MAX_PKT-th transfer of the packet, SHALL update last_grant, clear busy and return to IDLE.
REQ-021 A requester that drops req_valid mid-packet SHALL keep the grant; the arbiter SHALL wait indefinitely with no timeout.
REQ-022 Requests that arrive during a packet SHALL NOT pre-empt it.
REQ-023 A new arbitration SHALL start no earlier than 2 cycles after the last byte transfer (DATA->IDLE->ARB).
REQ-024 The byte counter SHALL be $clog2(MAX_PKT+1) bits wide, clear in ARB, and never wrap within a packet.
REQ-025 req_ready SHALL be all-zero outside DATA.

Reset
REQ-026 While rst_n=0: state=IDLE, tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), byte counter=0.
REQ-027 Reset asserted mid-packet SHALL abort the packet immediately; any partial frame is the transmitter's concern.

Configuration
REQ-028 With UART_ARB_TAG_EN defined, TAG SHALL present tx_data=8'hA0|grant_id with tx_valid=1 and go to DATA on the transfer; the tag byte SHALL NOT count toward MAX_PKT.
REQ-029 Without UART_ARB_TAG_EN, the TAG state SHALL be unreachable and no tag byte SHALL be sent.

Structure
REQ-030 Package uart_pkg SHALL hold the arb_state_t enum, the TAG_BASE=8'hA0 constant and the NUM_REQ/MAX_PKT defaults.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (request vector and last_grant in; grant index and found out; combinational).
REQ-032 uart_tx_arb SHALL contain only the FSM, counter, registers and muxing.

Verification
REQ-033 After reset, req_valid=4'b0101 with req_last=1 and tx_ready=1 SHALL produce the order requester 0 then requester 2, one byte each, and grant_id 0 then 2.
REQ-034 Requester 1 sends a 3-byte packet 11,22,33 while requester 3 is also valid SHALL produce bytes 11,22,33 contiguously before any byte from requester 3.
REQ-035 A packet of 20 bytes with no req_last and MAX_PKT=16 SHALL release the grant after 16 transfers and re-arbitrate.
REQ-036 Holding tx_ready=0 for 50 cycles mid-packet SHALL keep tx_data stable, keep req_ready=0 and lose no byte.
REQ-037 With UART_ARB_TAG_EN, a grant to requester 2 sending byte 3C SHALL produce A2 followed by 3C.
REQ-038 Asserting rst_n=0 during DATA SHALL return all outputs to their reset values asynchronously, and the next grant SHALL go to requester 0.
